// File: rtl/pulse_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pulse_chk_pkg
// Brief   : State encodings, default expected width and width-counter helpers
//           shared by the pulse checker.
// Revision: 1.0 - initial release
// ============================================================================
package pulse_chk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_ARM  = 2'd0;
    localparam state_t S_IDLE = 2'd1;
    localparam state_t S_MEAS = 2'd2;
    localparam state_t S_OVER = 2'd3;

    localparam int EXP_WIDTH_DEF = 3;

    localparam logic [3:0] WIDTH_MAX = 4'd15;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == WIDTH_MAX) ? v : v + 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear; clear beats increment.
// Revision: 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pulse_checker.sv
`default_nettype none
// ============================================================================
// Module  : pulse_checker
// Brief   : Measures high pulses on X, classifies them against EXP_WIDTH and
//           keeps good/error pulse counts. ErrCnt is built only when
//           PULSE_CHK_ERRCNT_EN is defined, otherwise it is tied to zero.
// Revision: 1.0 - initial release
// ============================================================================
module pulse_checker
    import pulse_chk_pkg::*;
#(
    parameter int EXP_WIDTH = EXP_WIDTH_DEF,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             X,
    input  logic             Clr,
    output logic             PulseOk,
    output logic             PulseShort,
    output logic             PulseLong,
    output logic [3:0]       Width,
    output logic [CNT_W-1:0] GoodCnt,
    output logic [CNT_W-1:0] ErrCnt,
    output logic [1:0]       State
);

    localparam logic [3:0] c_EXP = 4'(EXP_WIDTH);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_width;
    logic [3:0] w_width_nxt;
    logic       r_ok;
    logic       r_short;
    logic       r_long;
    logic       w_ok;
    logic       w_short;
    logic       w_long;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_width_nxt = r_width;
        w_ok        = 1'b0;
        w_short     = 1'b0;
        w_long      = 1'b0;
        case (r_state)
            // A pulse already in progress at reset release is not measured.
            S_ARM: begin
                w_cnt_nxt = 4'd0;
                if (!X) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (X) begin
                    w_state_nxt = S_MEAS;
                    w_cnt_nxt   = 4'd1;
                end
            end
            S_MEAS: begin
                if (X) begin
                    w_cnt_nxt = sat_inc4(r_cnt);
                    if (r_cnt == c_EXP) begin
                        w_state_nxt = S_OVER;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_width_nxt = r_cnt;
                    if (r_cnt == c_EXP) begin
                        w_ok = 1'b1;
                    end else begin
                        w_short = 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (X) begin
                    w_cnt_nxt = sat_inc4(r_cnt);
                end else begin
                    w_state_nxt = S_IDLE;
                    w_width_nxt = r_cnt;
                    w_long      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_ARM;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state <= S_ARM;
            r_cnt   <= 4'd0;
            r_width <= 4'd0;
            r_ok    <= 1'b0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_width <= w_width_nxt;
            r_ok    <= w_ok;
            r_short <= w_short;
            r_long  <= w_long;
        end
    end

    // Counters step on the same edge that raises the strobe they count.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_good_cnt (
        .clk     (Clk),
        .rst_n   (Rst),
        .i_inc   (w_ok),
        .i_clr   (Clr),
        .o_count (GoodCnt)
    );

`ifdef PULSE_CHK_ERRCNT_EN
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk     (Clk),
        .rst_n   (Rst),
        .i_inc   (w_short | w_long),
        .i_clr   (Clr),
        .o_count (ErrCnt)
    );
`else
    assign ErrCnt = '0;
`endif

    assign PulseOk    = r_ok;
    assign PulseShort = r_short;
    assign PulseLong  = r_long;
    assign Width      = r_width;
    assign State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pulse_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_pulse_checker
// Brief   : Self-checking bench for pulse_checker against a run-length model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pulse_checker;

    localparam int EXP = 3;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PULSE_CHK_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          X   = 1'b0;
    logic          Clr = 1'b0;
    logic          PulseOk;
    logic          PulseShort;
    logic          PulseLong;
    logic [3:0]    Width;
    logic [CW-1:0] GoodCnt;
    logic [CW-1:0] ErrCnt;
    logic [1:0]    State;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current high run and pulse outcomes.
    bit m_armed;
    int m_run;
    bit m_ok, m_short, m_long;
    int m_width, m_good, m_err;

    pulse_checker #(
        .EXP_WIDTH (EXP),
        .CNT_W     (CW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .X          (X),
        .Clr        (Clr),
        .PulseOk    (PulseOk),
        .PulseShort (PulseShort),
        .PulseLong  (PulseLong),
        .Width      (Width),
        .GoodCnt    (GoodCnt),
        .ErrCnt     (ErrCnt),
        .State      (State)
    );

    always #5 Clk = ~Clk;

    task automatic model_update(input logic x, input logic clr, input logic rst_n);
        m_ok    = 1'b0;
        m_short = 1'b0;
        m_long  = 1'b0;
        if (!rst_n) begin
            m_armed = 1'b0;
            m_run   = 0;
            m_width = 0;
            m_good  = 0;
            m_err   = 0;
            return;
        end
        if (!m_armed) begin
            if (!x) m_armed = 1'b1;
        end else if (x) begin
            m_run++;
        end else if (m_run > 0) begin
            if (m_run == EXP)     m_ok    = 1'b1;
            else if (m_run < EXP) m_short = 1'b1;
            else                  m_long  = 1'b1;
            m_width = (m_run > 15) ? 15 : m_run;
            m_run   = 0;
        end
        if (clr) begin
            m_good = 0;
            m_err  = 0;
        end else begin
            if (m_ok && m_good < CMAX) m_good++;
            if (ERR_EN && (m_short || m_long) && m_err < CMAX) m_err++;
        end
    endtask

    function automatic logic [24:0] exp_vec();
        logic [1:0] st;
        if (!m_armed)         st = 2'd0;
        else if (m_run == 0)  st = 2'd1;
        else if (m_run <= EXP) st = 2'd2;
        else                  st = 2'd3;
        return {st, m_ok, m_short, m_long, 4'(m_width), 8'(m_good), 8'(m_err)};
    endfunction

    function automatic logic [24:0] got_vec();
        return {State, PulseOk, PulseShort, PulseLong, Width, GoodCnt, ErrCnt};
    endfunction

    task automatic step(input logic x, input logic clr, input logic rst_n);
        X   = x;
        Clr = clr;
        Rst = rst_n;
        @(posedge Clk);
        model_update(x, clr, rst_n);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (got_vec() !== 25'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got_vec(), 25'd0);
        end
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h expected %h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(i < 3, 1'b0, 1'b1);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (PulseOk !== 1'b1 || Width !== 4'd3 || GoodCnt !== 8'd1) begin
            errors++;
            $display("FAIL basic_ok: got ok=%b w=%0d good=%0d expected ok=1 w=3 good=1",
                     PulseOk, Width, GoodCnt);
        end
    endtask

    task automatic test_short_long();
        logic [8:0] pat;
        pat = 9'b001111110; // LSB first: 0,1,1,1,1,1,1,0,0 after a 1-cycle pulse
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (PulseShort !== 1'b1 || PulseOk !== 1'b0 || Width !== 4'd1) begin
            errors++;
            $display("FAIL short: got s=%b ok=%b w=%0d expected s=1 ok=0 w=1",
                     PulseShort, PulseOk, Width);
        end
        for (int i = 1; i < 8; i++) begin
            step(pat[i], 1'b0, 1'b1);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL short_long cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (PulseLong !== 1'b1 || Width !== 4'd6 || ErrCnt !== (ERR_EN ? 8'd2 : 8'd0)) begin
            errors++;
            $display("FAIL long6: got l=%b w=%0d err=%0d expected l=1 w=6 err=%0d",
                     PulseLong, Width, ErrCnt, ERR_EN ? 2 : 0);
        end
    endtask

    task automatic test_rearm();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if ({PulseOk, PulseShort, PulseLong} !== 3'b000 || State !== 2'd1) begin
            errors++;
            $display("FAIL rearm_partial: got strobes=%b st=%0d expected 000 st=1",
                     {PulseOk, PulseShort, PulseLong}, State);
        end
        for (int i = 0; i < 4; i++) step(i < 3, 1'b0, 1'b1);
        checks++;
        if (PulseOk !== 1'b1 || got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rearm_ok: got %h expected %h", got_vec(), exp_vec());
        end
        // Reset in the middle of a pulse, then release while X is still high.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i < 2, 1'b0, 1'b1);
            checks++;
            if (got_vec() !== exp_vec() || {PulseOk, PulseShort, PulseLong} !== 3'b000) begin
                errors++;
                $display("FAIL abort cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_saturation();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 4; i++) begin
                step(i < 3, 1'b0, 1'b1);
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL sat p%0d c%0d: got %h expected %h", p, i, got_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (GoodCnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_good: got %0d expected 255", GoodCnt);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++;
        if (PulseOk !== 1'b1 || GoodCnt !== 8'd0 || Width !== 4'd3) begin
            errors++;
            $display("FAIL clr_wins: got ok=%b good=%0d w=%0d expected ok=1 good=0 w=3",
                     PulseOk, GoodCnt, Width);
        end
    endtask

    task automatic test_long();
        int strobes;
        strobes = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 23; i++) begin
            step(i < 20, 1'b0, 1'b1);
            strobes += PulseOk + PulseShort + PulseLong;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL long cyc %0d: got %h expected %h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (strobes != 1 || Width !== 4'd15) begin
            errors++;
            $display("FAIL long20: got strobes=%0d w=%0d expected strobes=1 w=15", strobes, Width);
        end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 4; i++) begin
                step(i < 3, 1'b0, 1'b1);
                checks++;
                if (PulseOk !== ((i == 3) ? 1'b1 : 1'b0) || got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL b2b p%0d c%0d: got %h expected %h", p, i, got_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        int hi, lo;
        logic c, r;
        step(1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 250; n++) begin
            hi = $urandom_range(1, 18);
            lo = $urandom_range(1, 4);
            for (int i = 0; i < hi + lo; i++) begin
                c = ($urandom_range(0, 49) == 0);
                r = ($urandom_range(0, 399) != 0);
                step(i < hi, c, r);
                checks++;
                if (got_vec() !== exp_vec() || (PulseOk + PulseShort + PulseLong) > 1) begin
                    errors++;
                    $display("FAIL random n%0d c%0d: got %h expected %h", n, i, got_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_long();
        test_rearm();
        test_saturation();
        test_long();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pulse_checker.md
PULSE_CHECKER -- requirements
Module: pulse_checker

Interface
REQ-001 Parameter EXP_WIDTH, default 3, SHALL set the expected high-pulse width in clock cycles (legal 1..14).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the pulse counters.
REQ-003 Clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 Rst  input  1  SHALL be a synchronous, active-low reset.
REQ-005 X  input  1  SHALL be the monitored pulse line, synchronous to Clk.
REQ-006 Clr  input  1  SHALL synchronously clear GoodCnt and ErrCnt.
REQ-007 PulseOk  output  1  SHALL be a one-cycle strobe for a pulse of exactly EXP_WIDTH.
REQ-008 PulseShort  output  1  SHALL be a one-cycle strobe for a pulse shorter than EXP_WIDTH.
REQ-009 PulseLong  output  1  SHALL be a one-cycle strobe for a pulse longer than EXP_WIDTH.
REQ-010 Width  output  4  SHALL hold the last completed pulse width, saturating at 15.
REQ-011 GoodCnt  output  CNT_W  SHALL count PulseOk events, saturating at all-ones.
REQ-012 ErrCnt  output  CNT_W  SHALL count PulseShort plus PulseLong events, saturating.
REQ-013 State  output  2  SHALL expose the current FSM state.

Function
REQ-014 FSM states SHALL be S_Arm=0, S_Idle=1, S_Meas=2, S_Over=3.
REQ-015 S_Arm: X=0 -> S_Idle; X=1 -> stay (partial pulse after reset is ignored).
REQ-016 S_Idle: X=1 -> S_Meas with width counter=1; X=0 -> stay.
REQ-017 S_Meas: X=1 and counter<EXP_WIDTH -> counter+1, stay; X=1 and counter=EXP_WIDTH -> counter+1, S_Over.
REQ-018 S_Meas: X=0 -> S_Idle; the classification SHALL be counter=EXP_WIDTH -> PulseOk, else PulseShort.
REQ-019 S_Over: X=1 -> counter+1 saturating at 15, stay; X=0 -> S_Idle with PulseLong.
REQ-020 Strobes and Width SHALL update on the edge that samples the first X=0, so they are visible one cycle after the falling edge of X.
REQ-021 At most one strobe SHALL be asserted in any cycle.
REQ-022 Width SHALL hold its value until the next pulse completes.
REQ-023 A back-to-back pulse (X low for exactly one cycle) SHALL be measured correctly.
REQ-024 Counters SHALL not wrap; at all-ones an increment is dropped.
REQ-025 Clr coincident with an increment SHALL leave the counter at 0 (Clr wins).
REQ-026 Clr SHALL not affect the FSM, Width, or the strobes.

Reset
REQ-027 With Rst=0 at a rising edge: State=S_Arm, all strobes=0, Width=0, GoodCnt=0, ErrCnt=0, width counter=0.
REQ-028 Reset asserted mid-pulse SHALL abort the pulse with no strobe, and the FSM SHALL re-arm only after X is seen low.

Configuration
REQ-029 Macro PULSE_CHK_ERRCNT_EN defined: ErrCnt SHALL be implemented per REQ-012.
REQ-030 Macro PULSE_CHK_ERRCNT_EN undefined: ErrCnt SHALL be tied to 0 and no counter logic generated; the port list is unchanged.

Structure
REQ-031 Package pulse_chk_pkg SHALL hold the state encodings and the EXP_WIDTH default.
REQ-032 Sub-module sat_counter (parameterised width, inc/clr inputs, saturating) SHALL implement both counters.

Verification
REQ-033 Reset, X=0, then X high for 3 cycles -> PulseOk one cycle after the fall, Width=3, GoodCnt=1.
REQ-034 X high for 1 cycle, then high for 6 cycles -> PulseShort with Width=1, then PulseLong with Width=6, ErrCnt=2 (0 with macro off).
REQ-035 X held high through reset release, then high 2 more cycles, low, then a 3-cycle pulse -> no strobe for the first pulse, PulseOk for the second.
REQ-036 256 good pulses with CNT_W=8 -> GoodCnt=255 saturated; Clr coincident with a PulseOk -> GoodCnt=0.
REQ-037 X high for 20 cycles -> single PulseLong, Width=15; pulses 3-high/1-low repeated -> PulseOk every 4 cycles.
